// File: rtl/button_led_ctrl.sv
// Multi-channel switch debouncer with press strobes and per-channel LED modes
// (follow / toggle / stretch / off). All state is clocked on sysclk.
module button_led_ctrl #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1,
   parameter int PULSE_LEN   = 5_000_000
) (
   input  logic                  sysclk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   sw_i,
   input  logic [CNT_W-1:0]      max_value,
   input  logic [2*CHANNELS-1:0] mode_i,
   output logic [CHANNELS-1:0]   db_o,
   output logic [CHANNELS-1:0]   press_o,
   output logic [CHANNELS-1:0]   led_o
);

   localparam int STR_W = $clog2(PULSE_LEN + 1);
   localparam logic INACT = (ACTIVE_LOW != 0);
   localparam logic [STR_W-1:0] PULSE_LD = STR_W'(PULSE_LEN);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   db_q;
      logic                   press_q;
      logic                   tog_q;
      logic                   tog_d;
      logic [STR_W-1:0]       str_q;
      logic [STR_W-1:0]       str_d;
      logic                   led_q;
      logic                   led_d;
      logic                   sync_s;
      logic                   mismatch;
      logic                   hit;

      assign sync_s   = sync_q[SYNC_STAGES-1];
      assign mismatch = (sync_s != db_q);
      assign hit      = mismatch && (cnt_q == max_value);

      always_ff @(posedge sysclk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{INACT}};
            db_q    <= INACT;
            cnt_q   <= '0;
            press_q <= 1'b0;
         end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_i[k]};
            press_q <= hit && (sync_s != INACT);
            if (hit) begin
               db_q  <= sync_s;
               cnt_q <= '0;
            end else if (mismatch) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end else begin
               cnt_q <= '0;
            end
         end
      end

      always_comb begin
         tog_d = tog_q ^ press_q;
         str_d = str_q;
         if (press_q) begin
            str_d = PULSE_LD;
         end else if (str_q != '0) begin
            str_d = str_q - STR_W'(1);
         end
      end

      // LED samples the next toggle/stretch state so every mode reacts on
      // the edge right after the press strobe, like follow mode does.
      always_comb begin
         led_d = 1'b0;
         case (mode_i[2*k +: 2])
            2'b00:   led_d = (db_q != INACT);
            2'b01:   led_d = tog_d;
            2'b10:   led_d = (str_d != '0);
            default: led_d = 1'b0;
         endcase
      end

      always_ff @(posedge sysclk or negedge rst_n) begin
         if (!rst_n) begin
            tog_q <= 1'b0;
            str_q <= '0;
            led_q <= 1'b0;
         end else begin
            tog_q <= tog_d;
            str_q <= str_d;
            led_q <= led_d;
         end
      end

      assign db_o[k]    = db_q;
      assign press_o[k] = press_q;
      assign led_o[k]   = led_q;
   end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Scoreboard bench for button_led_ctrl: stimulus pushes timed expected press
// and LED events; a negedge monitor pops and compares whenever they occur.
module tb_button_led_ctrl;

   logic        sysclk = 1'b0;
   logic        rst_n;
   logic [3:0]  sw_i;
   logic [7:0]  max_value;
   logic [7:0]  mode_i;
   logic [3:0]  db_o;
   logic [3:0]  press_o;
   logic [3:0]  led_o;

   logic [31:0] cyc = 32'd0;
   int          errors = 0;
   int          checks = 0;
   logic [39:0] press_exp_q[$];
   logic [35:0] led_exp_q[$];
   logic [3:0]  led_prev = 4'h0;
   logic [39:0] pe;
   logic [35:0] le;
   logic [31:0] n;

   button_led_ctrl #(
      .CHANNELS(4), .CNT_W(8), .SYNC_STAGES(2), .ACTIVE_LOW(1), .PULSE_LEN(5)
   ) dut (
      .sysclk(sysclk), .rst_n(rst_n), .sw_i(sw_i), .max_value(max_value),
      .mode_i(mode_i), .db_o(db_o), .press_o(press_o), .led_o(led_o)
   );

   // clock / cycle counter
   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 32'd1;

   // monitor
   always @(negedge sysclk) begin
      if (press_o != 4'h0) begin
         checks++;
         if (press_exp_q.size() == 0) begin
            errors++;
            $display("FAIL press_unexpected cyc=%0d press=%b db=%b", cyc, press_o, db_o);
         end else begin
            pe = press_exp_q.pop_front();
            if ({cyc, press_o, db_o} !== pe) begin
               errors++;
               $display("FAIL press_evt got cyc=%0d press=%b db=%b want cyc=%0d press=%b db=%b",
                        cyc, press_o, db_o, pe[39:8], pe[7:4], pe[3:0]);
            end
         end
      end
      if (led_o !== led_prev) begin
         checks++;
         if (led_exp_q.size() == 0) begin
            errors++;
            $display("FAIL led_unexpected cyc=%0d led=%b", cyc, led_o);
         end else begin
            le = led_exp_q.pop_front();
            if ({cyc, led_o} !== le) begin
               errors++;
               $display("FAIL led_evt got cyc=%0d led=%b want cyc=%0d led=%b",
                        cyc, led_o, le[35:4], le[3:0]);
            end
         end
      end
      led_prev = led_o;
   end

   // driver tasks
   task automatic step(input int cnt);
      repeat (cnt) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic exp_press(input logic [31:0] c, input logic [3:0] p, input logic [3:0] d);
      press_exp_q.push_back({c, p, d});
   endtask

   task automatic exp_led(input logic [31:0] c, input logic [3:0] l);
      led_exp_q.push_back({c, l});
   endtask

   task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   initial begin
      rst_n = 1'b0; sw_i = 4'hF; max_value = 8'd3; mode_i = 8'hE1;
      step(3);
      check4("rst_db", db_o, 4'hF);
      check4("rst_press", press_o, 4'h0);
      check4("rst_led", led_o, 4'h0);
      rst_n = 1'b1;
      step(3);

      // ch0 toggle: two presses
      for (int i = 0; i < 2; i++) begin
         n = cyc; sw_i[0] = 1'b0;
         exp_press(n + 6, 4'b0001, 4'b1110);
         exp_led(n + 7, (i == 0) ? 4'b0001 : 4'b0000);
         step(10); sw_i[0] = 1'b1; step(10);
      end

      // ch1 bounce of 3 synchronised cycles, twice
      for (int i = 0; i < 2; i++) begin
         sw_i[1] = 1'b0; step(3); sw_i[1] = 1'b1; step(8);
         check4("bounce_db", db_o, 4'hF);
      end

      // ch2 stretch, single press
      n = cyc; sw_i[2] = 1'b0;
      exp_press(n + 6, 4'b0100, 4'b1011);
      exp_led(n + 7, 4'b0100);
      exp_led(n + 12, 4'b0000);
      step(8); sw_i[2] = 1'b1; step(12);

      // all channels at once, modes 00/01/10/11
      mode_i = 8'hE4; step(2);
      n = cyc; sw_i = 4'h0;
      exp_press(n + 6, 4'hF, 4'h0);
      exp_led(n + 7, 4'b0111);
      exp_led(n + 12, 4'b0011);
      step(13); sw_i = 4'hF;
      exp_led(cyc + 7, 4'b0010);
      step(10);

      // mode change preserves toggle state
      n = cyc; mode_i = 8'hEC; exp_led(n + 1, 4'b0000); step(3);
      n = cyc; mode_i = 8'hE4; exp_led(n + 1, 4'b0010); step(3);

      // reset mid-debounce (ch0 count=2)
      sw_i[0] = 1'b0; step(4);
      rst_n = 1'b0; exp_led(cyc, 4'b0000);
      #1;
      check4("midrst_db", db_o, 4'hF);
      check4("midrst_press", press_o, 4'h0);
      check4("midrst_led", led_o, 4'h0);
      step(3);
      rst_n = 1'b1; n = cyc;
      exp_press(n + 6, 4'b0001, 4'b1110);
      exp_led(n + 7, 4'b0001);
      step(10); sw_i[0] = 1'b1;
      exp_led(cyc + 7, 4'b0000);
      step(10);

      // M=0: single-cycle debounce, glitch accepted, stretch retrigger
      mode_i = 8'hE3; max_value = 8'd0; step(2);
      n = cyc; sw_i[1] = 1'b0;
      exp_press(n + 3, 4'b0010, 4'b1101);
      exp_led(n + 4, 4'b0010);
      step(5); sw_i[1] = 1'b1;
      exp_led(cyc + 4, 4'b0000);
      step(6);

      n = cyc;
      exp_press(n + 3, 4'b0010, 4'b1101);
      exp_led(n + 4, 4'b0010);
      exp_led(n + 5, 4'b0000);
      sw_i[1] = 1'b0; step(1); sw_i[1] = 1'b1; step(8);

      n = cyc;
      exp_press(n + 3, 4'b0100, 4'b1011);
      exp_press(n + 7, 4'b0100, 4'b1011);
      exp_led(n + 4, 4'b0100);
      exp_led(n + 13, 4'b0000);
      sw_i[2] = 1'b0; step(1); sw_i[2] = 1'b1; step(3); sw_i[2] = 1'b0;
      step(16); sw_i[2] = 1'b1; step(6);

      // final report
      step(2);
      checks++;
      if (press_exp_q.size() != 0) begin
         errors++;
         $display("FAIL press_pending got=%0d want=0", press_exp_q.size());
      end
      checks++;
      if (led_exp_q.size() != 0) begin
         errors++;
         $display("FAIL led_pending got=%0d want=0", led_exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
